// File: rtl/bitpack_sched_pkg.sv
// Shared types for the bitstream job scheduler: FSM state encoding and the queued job descriptor.
package bitpack_sched_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RELEASE
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] size;
  } job_t;

endpackage

// File: rtl/sched_job_fifo.sv
// Small power-of-two FIFO holding job descriptors between host pushes and scheduler launches.
module sched_job_fifo
  import bitpack_sched_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = job_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  item_t data_i,
  input  logic  pop_i,
  output item_t data_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  item_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bitpack_job_sched.sv
// Queues host job descriptors and runs them one at a time on a bitstream wrapper via GO/DONE,
// retiring each job once DST_WORDS write beats have been seen and the write path has drained.
module bitpack_job_sched
  import bitpack_sched_pkg::*;
#(
  parameter int QDEPTH    = 4,
  parameter int DST_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [31:0]       job_src_i,
  input  logic [31:0]       job_dst_i,
  input  logic [31:0]       job_size_i,
  input  logic              enable_i,
  output logic              busy_o,
  output logic              job_done_o,
  output logic [CNT_W-1:0]  done_cnt_o,
  output logic [CNT_W-1:0]  rej_cnt_o,
  output logic              go_o,
  input  logic              w_done_i,
  output logic [31:0]       src_o,
  output logic [31:0]       dst_o,
  output logic [31:0]       size_o,
  input  logic              wr_valid_i,
  input  logic              wr_ready_i,
  input  logic              wr_busy_i
);

  localparam int BEAT_W = $clog2(DST_WORDS + 1);

  sched_state_t      state_q, state_d;
  job_t              job_q, job_d;
  logic              go_q, go_d;
  logic              job_done_q, job_done_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]  rej_cnt_q, rej_cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  job_t push_job;
  job_t head_job;
  logic push;
  logic pop;
  logic q_empty;
  logic q_full;

  assign push_job = '{src: job_src_i, dst: job_dst_i, size: job_size_i};
  assign push     = job_valid_i && job_ready_o;

  sched_job_fifo #(
    .DEPTH  (QDEPTH),
    .item_t (job_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_job),
    .pop_i   (pop),
    .data_o  (head_job),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    beat_d     = beat_q;
    done_cnt_d = done_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    job_done_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Zero-length jobs are dropped even while launches are disabled or the wrapper is busy.
        if (!q_empty) begin
          if (head_job.size == '0) begin
            pop       = 1'b1;
            rej_cnt_d = rej_cnt_q + CNT_W'(1);
          end else if (enable_i && w_done_i) begin
            pop     = 1'b1;
            job_d   = head_job;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (!w_done_i) begin
          state_d = S_RUN;
          beat_d  = '0;
        end
      end
      S_RUN: begin
        if (wr_valid_i && wr_ready_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(DST_WORDS - 1)) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (w_done_i && !wr_busy_i) begin
          job_done_d = 1'b1;
          done_cnt_d = done_cnt_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // GO follows the next state so it drops on the edge that samples the final beat.
    go_d = (state_d == S_LAUNCH) || (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      job_q      <= '0;
      go_q       <= 1'b0;
      job_done_q <= 1'b0;
      done_cnt_q <= '0;
      rej_cnt_q  <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      job_q      <= job_d;
      go_q       <= go_d;
      job_done_q <= job_done_d;
      done_cnt_q <= done_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
      beat_q     <= beat_d;
    end
  end

  assign job_ready_o = !q_full;
  assign busy_o      = (state_q != S_IDLE) || !q_empty;
  assign job_done_o  = job_done_q;
  assign done_cnt_o  = done_cnt_q;
  assign rej_cnt_o   = rej_cnt_q;
  assign go_o        = go_q;
  assign src_o       = job_q.src;
  assign dst_o       = job_q.dst;
  assign size_o      = job_q.size;

endmodule

// File: tb/tb_bitpack_job_sched.sv
// Self-checking bench: behavioural wrapper model, queue-based job model and event monitor.
module tb_bitpack_job_sched;
  import bitpack_sched_pkg::*;

  localparam int QDEPTH    = 4;
  localparam int DST_WORDS = 2;
  localparam int CNT_W     = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             job_valid_i;
  logic             job_ready_o;
  logic [31:0]      job_src_i, job_dst_i, job_size_i;
  logic             enable_i;
  logic             busy_o;
  logic             job_done_o;
  logic [CNT_W-1:0] done_cnt_o, rej_cnt_o;
  logic             go_o;
  logic             w_done_i;
  logic [31:0]      src_o, dst_o, size_o;
  logic             wr_valid_i, wr_ready_i, wr_busy_i;

  bitpack_job_sched #(
    .QDEPTH(QDEPTH), .DST_WORDS(DST_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_size_i(job_size_i),
    .enable_i(enable_i), .busy_o(busy_o), .job_done_o(job_done_o),
    .done_cnt_o(done_cnt_o), .rej_cnt_o(rej_cnt_o),
    .go_o(go_o), .w_done_i(w_done_i),
    .src_o(src_o), .dst_o(dst_o), .size_o(size_o),
    .wr_valid_i(wr_valid_i), .wr_ready_i(wr_ready_i), .wr_busy_i(wr_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic job_t mk_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    job_t j;
    j.src  = s;
    j.dst  = d;
    j.size = z;
    return j;
  endfunction

  // ---------------- wrapper model ----------------
  typedef enum {W_IDLE, W_ARMED, W_COMPUTE, W_WRITE, W_DRAIN, W_BUSY} wst_t;
  wst_t wst = W_IDLE;
  int   ready_mode = 0;   // 0 always ready, 1 one cycle in three, 2 random
  int   busy_hold  = 0;

  initial begin
    int  timer, beats, busy_left, rdy_phase;
    bit  hs;
    w_done_i = 1'b1; wr_valid_i = 1'b0; wr_ready_i = 1'b1; wr_busy_i = 1'b0;
    timer = 0; beats = 0; busy_left = 0; rdy_phase = 0;
    forever begin
      @(posedge clk_i);
      #1;
      hs = wr_valid_i && wr_ready_i;
      case (wst)
        W_IDLE:    if (go_o) wst = W_ARMED;
        W_ARMED:   begin w_done_i = 1'b0; timer = int'(size_o); wst = W_COMPUTE; end
        W_COMPUTE: begin
          if (timer <= 1) begin wr_valid_i = 1'b1; beats = 0; wst = W_WRITE; end
          else timer--;
        end
        W_WRITE: begin
          if (hs) begin
            beats++;
            if (beats == DST_WORDS) begin wr_valid_i = 1'b0; wst = W_DRAIN; end
          end
        end
        W_DRAIN: begin
          if (!go_o) begin
            w_done_i = 1'b1;
            if (busy_hold > 0) begin wr_busy_i = 1'b1; busy_left = busy_hold; wst = W_BUSY; end
            else wst = W_IDLE;
          end
        end
        W_BUSY: begin
          busy_left--;
          if (busy_left == 0) begin wr_busy_i = 1'b0; wst = W_IDLE; end
        end
        default: wst = W_IDLE;
      endcase
      case (ready_mode)
        0: wr_ready_i = 1'b1;
        1: begin rdy_phase = (rdy_phase + 1) % 3; wr_ready_i = (rdy_phase == 0); end
        default: wr_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model and monitor ----------------
  job_t             exp_q[$];
  logic [CNT_W-1:0] model_done = '0;
  logic [CNT_W-1:0] model_rej  = '0;

  initial begin
    job_t             cap, e;
    bit               in_job, hold_ok, prev_go, prev_wdone, hs_pend;
    int               job_beats;
    logic [CNT_W-1:0] nxt;
    cap = '0; in_job = 0; hold_ok = 1; prev_go = 0; prev_wdone = 1; hs_pend = 0; job_beats = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        model_done = '0; model_rej = '0;
        in_job = 0; prev_go = 0; hs_pend = 0;
        prev_wdone = w_done_i;
        continue;
      end
      if (hs_pend && in_job) begin
        job_beats++;
        if (job_beats == DST_WORDS) check("go_drop_after_last_beat", go_o, 0);
        else if (job_beats < DST_WORDS) check("go_held_between_beats", go_o, 1);
      end
      if (go_o && !prev_go) begin
        check("go_rise_needs_wdone", prev_wdone, 1);
        cap = mk_job(src_o, dst_o, size_o);
        in_job = 1; job_beats = 0; hold_ok = 1;
      end
      if (in_job && (mk_job(src_o, dst_o, size_o) != cap)) hold_ok = 0;
      if (job_done_o) begin
        if (!in_job || exp_q.size() == 0) begin
          check("unexpected_job_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("retire_src", cap.src, e.src);
          check("retire_dst", cap.dst, e.dst);
          check("retire_size", cap.size, e.size);
          check("retire_beats", job_beats, DST_WORDS);
          check("retire_desc_stable", hold_ok, 1);
          nxt = model_done + 1'b1;
          check("retire_done_cnt", done_cnt_o, nxt);
          model_done = nxt;
        end
        in_job = 0;
      end
      if (job_valid_i && job_ready_o) begin
        if (job_size_i == '0) model_rej = model_rej + 1'b1;
        else exp_q.push_back(mk_job(job_src_i, job_dst_i, job_size_i));
      end
      hs_pend    = wr_valid_i && wr_ready_i;
      prev_go    = go_o;
      prev_wdone = w_done_i;
    end
  end

  // ---------------- host-side helpers ----------------
  task automatic push_job(input job_t j);
    bit acc = 0;
    job_valid_i = 1'b1;
    job_src_i = j.src; job_dst_i = j.dst; job_size_i = j.size;
    for (int i = 0; i < 300; i++) begin
      acc = job_ready_o;
      tick();
      if (acc) break;
    end
    job_valid_i = 1'b0;
    if (!acc) check("push_timeout", acc, 1);
  endtask

  function automatic job_t rand_job(input int min_size, input int max_size);
    return mk_job($urandom, $urandom, 32'($urandom_range(max_size, min_size)));
  endfunction

  task automatic expect_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy_o && wst == W_IDLE && !wr_busy_i) begin ok = 1; break; end
      tick();
    end
    check({tag, "_reached_idle"}, ok, 1);
    tick(); tick();
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done_cnt"}, done_cnt_o, model_done);
    check({tag, "_rej_cnt"}, rej_cnt_o, model_rej);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random tests ----------------
  initial begin
    logic [CNT_W-1:0] base_done, base_rej;
    job_t             j;
    bit               seen_busy, early, go_ok;
    int               t_fall, t_done;

    rst_i = 1'b1; job_valid_i = 1'b0; enable_i = 1'b0;
    job_src_i = '0; job_dst_i = '0; job_size_i = '0;
    #12;
    check("rst_job_ready", job_ready_o, 1);
    check("rst_go", go_o, 0);
    check("rst_job_done", job_done_o, 0);
    check("rst_done_cnt", done_cnt_o, 0);
    check("rst_rej_cnt", rej_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_desc", {src_o, dst_o, size_o}, 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_job_ready", job_ready_o, 1);

    // 1: single job, launch latency and retire
    enable_i = 1'b1;
    push_job(mk_job(32'h1000, 32'h2000, 32'd8));
    check("t1_go_one_cycle_after_push", go_o, 0);
    tick();
    check("t1_go_two_cycles_after_push", go_o, 1);
    check("t1_src", src_o, 32'h1000);
    expect_idle("t1");
    check("t1_done_cnt_is_1", done_cnt_o, 1);

    // 2: fill the queue with launches disabled, overflow push ignored, FIFO order on release
    enable_i  = 1'b0;
    base_done = done_cnt_o;
    for (int i = 0; i < QDEPTH; i++) push_job(rand_job(1, 12));
    check("t2_ready_low_when_full", job_ready_o, 0);
    job_valid_i = 1'b1;
    j = rand_job(1, 12);
    job_src_i = j.src; job_dst_i = j.dst; job_size_i = j.size;
    tick();
    job_valid_i = 1'b0;
    check("t2_ready_still_low", job_ready_o, 0);
    check("t2_no_launch_disabled", go_o, 0);
    enable_i = 1'b1;
    expect_idle("t2");
    check("t2_retired_count", 16'(done_cnt_o - base_done), QDEPTH);

    // 3: zero-size job rejected, following job runs
    base_done = done_cnt_o; base_rej = rej_cnt_o;
    push_job(mk_job(32'hA0, 32'hB0, 32'd0));
    push_job(mk_job(32'hA4, 32'hB4, 32'd4));
    expect_idle("t3");
    check("t3_rej_delta", 16'(rej_cnt_o - base_rej), 1);
    check("t3_done_delta", 16'(done_cnt_o - base_done), 1);

    // 4: write path stays busy after GO falls; retire waits for it
    busy_hold = 10;
    push_job(rand_job(2, 6));
    seen_busy = 0; early = 0; t_fall = -1; t_done = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      if (wr_busy_i) begin
        seen_busy = 1;
        if (job_done_o) early = 1;
      end else if (seen_busy && t_fall < 0) t_fall = c;
      if (job_done_o && t_done < 0) begin t_done = c; break; end
    end
    tick();
    check("t4_busy_phase_seen", seen_busy, 1);
    check("t4_no_done_while_busy", early, 0);
    check("t4_done_cycle_after_busy_falls", t_done - t_fall, 1);
    expect_idle("t4");
    busy_hold = 0;

    // 5: throttled write handshake
    ready_mode = 1;
    for (int i = 0; i < 3; i++) push_job(rand_job(1, 5));
    expect_idle("t5");
    ready_mode = 0;

    // 6: reset in the middle of a running job with two more queued
    push_job(mk_job(32'h6000, 32'h7000, 32'd30));
    push_job(rand_job(3, 5));
    push_job(rand_job(3, 5));
    for (int i = 0; i < 50 && w_done_i; i++) tick();
    tick(); tick();
    check("t6_running_before_rst", go_o, 1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_go", go_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_done_cnt", done_cnt_o, 0);
    check("t6_rst_rej_cnt", rej_cnt_o, 0);
    tick();
    rst_i = 1'b0;
    go_ok = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (go_o) go_ok = 0; end
    push_job(mk_job(32'h6100, 32'h7100, 32'd3));
    for (int i = 0; i < 100 && !w_done_i; i++) begin
      if (go_o) go_ok = 0;
      tick();
    end
    check("t6_no_launch_while_wrapper_busy", go_ok, 1);
    expect_idle("t6");
    check("t6_done_cnt_after_rst", done_cnt_o, 1);

    // 7: random mix of sizes (including zero), enable toggling and ready jitter
    ready_mode = 2;
    for (int n = 0; n < 16; n++) begin
      enable_i = ($urandom_range(0, 3) != 0);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      if (!job_ready_o) enable_i = 1'b1;
      push_job(rand_job(0, 6));
    end
    enable_i = 1'b1;
    expect_idle("t7");
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
